// File: rtl/sram_bist_pkg.sv
// Shared types for the March C- SRAM BIST controller: FSM states and the
// per-element march encoding (direction, operation sequence, backgrounds).
package sram_bist_pkg;

    localparam int unsigned NUM_ELEM = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } bist_state_t;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } march_dir_t;

    // Two-op elements always issue the read first, then the write.
    typedef struct packed {
        march_dir_t dir;
        logic       has_rd;
        logic       has_wr;
        logic       rd_bg;
        logic       wr_bg;
    } march_elem_t;

    function automatic march_elem_t march_elem(input logic [2:0] idx);
        case (idx)
            3'd0:    return '{DIR_UP,   1'b0, 1'b1, 1'b0, 1'b0};
            3'd1:    return '{DIR_UP,   1'b1, 1'b1, 1'b0, 1'b1};
            3'd2:    return '{DIR_UP,   1'b1, 1'b1, 1'b1, 1'b0};
            3'd3:    return '{DIR_DOWN, 1'b1, 1'b1, 1'b0, 1'b1};
            3'd4:    return '{DIR_DOWN, 1'b1, 1'b1, 1'b1, 1'b0};
            3'd5:    return '{DIR_UP,   1'b1, 1'b0, 1'b0, 1'b0};
            default: return '{DIR_UP,   1'b0, 1'b0, 1'b0, 1'b0};
        endcase
    endfunction

endpackage

// File: rtl/sram_bist_cmp.sv
// One-stage pipelined read checker: registers the expectation with each read,
// compares against SRAM data at the next edge. SRAM_BIST_DIAG_EN enables the count.
module sram_bist_cmp #(
    parameter int P_DATA_WIDTH = 24,
    parameter int P_ADDR_WIDTH = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    rd_issue,
    input  logic [P_DATA_WIDTH-1:0] rd_exp,
    input  logic [P_ADDR_WIDTH-1:0] rd_addr,
    input  logic [2:0]              rd_elem,
    input  logic [P_DATA_WIDTH-1:0] rd_data,
    output logic                    fail,
    output logic [P_ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]              fail_elem,
    output logic [15:0]             fail_cnt
);

    logic                    pend_vld;
    logic [P_DATA_WIDTH-1:0] pend_exp;
    logic [P_ADDR_WIDTH-1:0] pend_addr;
    logic [2:0]              pend_elem;
    logic                    mismatch;

    assign mismatch = pend_vld && (rd_data != pend_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld  <= 1'b0;
            pend_exp  <= '0;
            pend_addr <= '0;
            pend_elem <= '0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
        end else if (clr) begin
            pend_vld  <= 1'b0;
            pend_exp  <= '0;
            pend_addr <= '0;
            pend_elem <= '0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
        end else begin
            pend_vld <= rd_issue;
            if (rd_issue) begin
                pend_exp  <= rd_exp;
                pend_addr <= rd_addr;
                pend_elem <= rd_elem;
            end
            // Only the first mismatch after a start is recorded.
            if (mismatch && !fail) begin
                fail      <= 1'b1;
                fail_addr <= pend_addr;
                fail_elem <= pend_elem;
            end
        end
    end

`ifdef SRAM_BIST_DIAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt <= '0;
        end else if (clr) begin
            fail_cnt <= '0;
        end else if (mismatch && (fail_cnt != '1)) begin
            fail_cnt <= fail_cnt + 16'd1;
        end
    end
`else
    assign fail_cnt = '0;
`endif

endmodule

// File: rtl/sram_march_bist_ctrl.sv
// March C- SRAM BIST sequencer. Define SRAM_BIST_DIAG_EN to run to completion
// and count all mismatches; otherwise the test stops at the first mismatch.
module sram_march_bist_ctrl
    import sram_bist_pkg::*;
#(
    parameter int P_DATA_WIDTH = 24,
    parameter int P_ADDR_WIDTH = 14
) (
    input  logic                    A_CLK,
    input  logic                    A_RST_N,
    input  logic                    A_START,
    output logic                    A_BUSY,
    output logic                    A_DONE,
    output logic                    A_FAIL,
    output logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR,
    output logic [2:0]              A_FAIL_ELEM,
    output logic [15:0]             A_FAIL_CNT,
    output logic                    A_BIST_EN,
    output logic                    A_BIST_MEN,
    output logic                    A_BIST_WEN,
    output logic                    A_BIST_REN,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
    output logic                    A_BIST_CLK,
    input  logic [P_DATA_WIDTH-1:0] A_BIST_DOUT
);

    bist_state_t             state, state_nxt;
    logic [2:0]              elem;
    logic [P_ADDR_WIDTH-1:0] cnt;
    logic                    phase;
    march_elem_t             cfg;
    logic [P_ADDR_WIDTH-1:0] phys_addr;
    logic                    start_ok, issue, is_rd, is_wr;
    logic                    last_op, last_addr, last_elem;
    logic                    fail, halt;

`ifdef SRAM_BIST_DIAG_EN
    assign halt = 1'b0;
`else
    assign halt = fail;
`endif

    assign A_BIST_CLK = A_CLK;

    always_ff @(posedge A_CLK or negedge A_RST_N) begin
        if (!A_RST_N) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // The counter always runs upward; down elements address the inverted count.
    always_comb begin
        cfg       = march_elem(elem);
        phys_addr = (cfg.dir == DIR_DOWN) ? ~cnt : cnt;
        start_ok  = ((state == ST_IDLE) || (state == ST_DONE)) && A_START;
        issue     = (state == ST_RUN) && !halt;
        is_rd     = issue && cfg.has_rd && !phase;
        is_wr     = issue && !is_rd;
        last_op   = !(cfg.has_rd && cfg.has_wr) || phase;
        last_addr = (cnt == '1);
        last_elem = (elem == 3'(NUM_ELEM - 1));

        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (A_START) state_nxt = ST_RUN;
            ST_RUN: begin
                if (halt)                               state_nxt = ST_DONE;
                else if (last_op && last_addr && last_elem) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase

        A_BUSY      = (state == ST_RUN) || (state == ST_DRAIN);
        A_DONE      = (state == ST_DONE);
        A_BIST_EN   = A_BUSY;
        A_BIST_MEN  = issue;
        A_BIST_WEN  = is_wr;
        A_BIST_REN  = is_rd;
        A_BIST_ADDR = issue ? phys_addr : '0;
        A_BIST_DIN  = is_wr ? {P_DATA_WIDTH{cfg.wr_bg}} : '0;
        A_BIST_BM   = '1;
    end

    always_ff @(posedge A_CLK or negedge A_RST_N) begin
        if (!A_RST_N) begin
            elem  <= '0;
            cnt   <= '0;
            phase <= 1'b0;
        end else if (start_ok) begin
            elem  <= '0;
            cnt   <= '0;
            phase <= 1'b0;
        end else if (issue) begin
            if (!last_op) begin
                phase <= 1'b1;
            end else begin
                phase <= 1'b0;
                cnt   <= cnt + 1'b1;
                if (last_addr) elem <= elem + 3'd1;
            end
        end
    end

    sram_bist_cmp #(
        .P_DATA_WIDTH(P_DATA_WIDTH),
        .P_ADDR_WIDTH(P_ADDR_WIDTH)
    ) u_cmp (
        .clk      (A_CLK),
        .rst_n    (A_RST_N),
        .clr      (start_ok),
        .rd_issue (is_rd),
        .rd_exp   ({P_DATA_WIDTH{cfg.rd_bg}}),
        .rd_addr  (phys_addr),
        .rd_elem  (elem),
        .rd_data  (A_BIST_DOUT),
        .fail     (fail),
        .fail_addr(A_FAIL_ADDR),
        .fail_elem(A_FAIL_ELEM),
        .fail_cnt (A_FAIL_CNT)
    );

    assign A_FAIL = fail;

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Directed bench for sram_march_bist_ctrl with a behavioural SRAM and an op scoreboard.
// Expectations follow SRAM_BIST_DIAG_EN when it is defined for the build.
module tb_sram_march_bist_ctrl;

    localparam int AW = 2;
    localparam int DW = 24;
    localparam int N  = 4;
    localparam int OV = 26 + 2*AW + 2*DW;

`ifdef SRAM_BIST_DIAG_EN
    localparam int EXP_S2  = 41;
    localparam int EXP_S0  = 41;
    localparam int EXP_CNT = 3;
`else
    localparam int EXP_S2  = 11;
    localparam int EXP_S0  = 7;
    localparam int EXP_CNT = 0;
`endif

    logic          A_CLK = 1'b0;
    logic          A_RST_N, A_START;
    logic          A_BUSY, A_DONE, A_FAIL;
    logic [AW-1:0] A_FAIL_ADDR;
    logic [2:0]    A_FAIL_ELEM;
    logic [15:0]   A_FAIL_CNT;
    logic          A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN;
    logic [AW-1:0] A_BIST_ADDR;
    logic [DW-1:0] A_BIST_DIN, A_BIST_BM, A_BIST_DOUT;
    logic          A_BIST_CLK;

    logic [DW-1:0] mem [N];
    logic          stuck_en;
    logic [AW-1:0] stuck_addr;

    int checks = 0;
    int errors = 0;
    int push_k;

    typedef struct packed {
        logic [15:0]   edge_no;
        logic          we;
        logic          re;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } op_t;

    op_t exp_q[$];

    always #5 A_CLK = ~A_CLK;

    sram_march_bist_ctrl #(
        .P_DATA_WIDTH(DW),
        .P_ADDR_WIDTH(AW)
    ) dut (
        .A_CLK      (A_CLK),
        .A_RST_N    (A_RST_N),
        .A_START    (A_START),
        .A_BUSY     (A_BUSY),
        .A_DONE     (A_DONE),
        .A_FAIL     (A_FAIL),
        .A_FAIL_ADDR(A_FAIL_ADDR),
        .A_FAIL_ELEM(A_FAIL_ELEM),
        .A_FAIL_CNT (A_FAIL_CNT),
        .A_BIST_EN  (A_BIST_EN),
        .A_BIST_MEN (A_BIST_MEN),
        .A_BIST_WEN (A_BIST_WEN),
        .A_BIST_REN (A_BIST_REN),
        .A_BIST_ADDR(A_BIST_ADDR),
        .A_BIST_DIN (A_BIST_DIN),
        .A_BIST_BM  (A_BIST_BM),
        .A_BIST_CLK (A_BIST_CLK),
        .A_BIST_DOUT(A_BIST_DOUT)
    );

    // Behavioural SRAM; a stuck-at-1 on bit 3 can be injected at one address.
    always @(posedge A_CLK) begin
        if (A_BIST_MEN && A_BIST_WEN) mem[A_BIST_ADDR] <= A_BIST_DIN & A_BIST_BM;
        if (A_BIST_MEN && A_BIST_REN)
            A_BIST_DOUT <= mem[A_BIST_ADDR] |
                           ((stuck_en && (A_BIST_ADDR == stuck_addr)) ? DW'(8) : DW'(0));
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OV-1:0] outvec();
        return {A_BUSY, A_DONE, A_FAIL, A_FAIL_ADDR, A_FAIL_ELEM, A_FAIL_CNT,
                A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
                A_BIST_ADDR, A_BIST_DIN, A_BIST_BM};
    endfunction

    task automatic push_op(input logic we, input int a, input logic bg);
        op_t o;
        o.edge_no = 16'(push_k);
        o.we      = we;
        o.re      = !we;
        o.addr    = AW'(a);
        o.din     = we ? {DW{bg}} : '0;
        exp_q.push_back(o);
        push_k++;
    endtask

    // March C- written out element by element.
    task automatic build_ops();
        exp_q.delete();
        push_k = 1;
        for (int a = 0; a < N; a++) push_op(1'b1, a, 1'b0);
        for (int a = 0; a < N; a++) begin push_op(1'b0, a, 1'b0); push_op(1'b1, a, 1'b1); end
        for (int a = 0; a < N; a++) begin push_op(1'b0, a, 1'b0); push_op(1'b1, a, 1'b0); end
        for (int a = N-1; a >= 0; a--) begin push_op(1'b0, a, 1'b0); push_op(1'b1, a, 1'b1); end
        for (int a = N-1; a >= 0; a--) begin push_op(1'b0, a, 1'b0); push_op(1'b1, a, 1'b0); end
        for (int a = 0; a < N; a++) push_op(1'b0, a, 1'b0);
    endtask

    task automatic run_march(input int exp_done, input int busy_start_edge,
                             input int rst_edge, input string tag);
        op_t got, want;
        int  done_edge;
        bit  stop;
        logic [OV-1:0] rstvec;
        rstvec = '0;
        rstvec[DW-1:0] = '1;
        build_ops();
        @(negedge A_CLK);
        A_START = 1'b1;
        @(posedge A_CLK);
        #1 A_START = 1'b0;
        check({tag, "_start_busy"}, A_BUSY, 1'b1);
        check({tag, "_start_clr"}, {A_FAIL, A_FAIL_ADDR, A_FAIL_ELEM, A_FAIL_CNT}, '0);
        done_edge = -1;
        stop = 1'b0;
        for (int e = 1; e <= 200 && !stop; e++) begin
            @(negedge A_CLK);
            if (e == busy_start_edge) A_START = 1'b1;
            if (A_BIST_MEN) begin
                got.edge_no = 16'(e);
                got.we      = A_BIST_WEN;
                got.re      = A_BIST_REN;
                got.addr    = A_BIST_ADDR;
                got.din     = A_BIST_WEN ? A_BIST_DIN : '0;
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_op"}, got, '0);
                end else begin
                    want = exp_q.pop_front();
                    check({tag, "_op"}, got, want);
                end
            end
            @(posedge A_CLK);
            #1 A_START = 1'b0;
            if (e == rst_edge) begin
                A_RST_N = 1'b0;
                #1 check({tag, "_reset_outputs"}, outvec(), rstvec);
                stop = 1'b1;
            end else if (A_DONE) begin
                done_edge = e;
                stop = 1'b1;
            end
        end
        if (rst_edge == 0) begin
            check({tag, "_done_edge"}, done_edge, exp_done);
            check({tag, "_done_quiet"},
                  {A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_EN, A_BUSY, A_BIST_BM},
                  {5'b0, {DW{1'b1}}});
        end
    endtask

    initial begin
        logic [OV-1:0] rv;
        rv = '0;
        rv[DW-1:0] = '1;
        A_RST_N    = 1'b0;
        A_START    = 1'b0;
        stuck_en   = 1'b0;
        stuck_addr = '0;

        repeat (3) @(posedge A_CLK);
        #1 check("reset_outputs", outvec(), rv);
        @(negedge A_CLK);
        A_RST_N = 1'b1;
        repeat (4) @(posedge A_CLK);
        #1 check("idle_after_reset", {A_BUSY, A_DONE, A_BIST_EN, A_BIST_MEN}, '0);

        run_march(41, 0, 0, "clean");
        check("clean_result", {A_DONE, A_FAIL, A_FAIL_CNT}, {1'b1, 17'b0});

        stuck_en   = 1'b1;
        stuck_addr = AW'(2);
        run_march(EXP_S2, 0, 0, "stuck2");
        check("stuck2_fail", {A_FAIL, A_FAIL_ADDR, A_FAIL_ELEM}, {1'b1, 2'd2, 3'd1});
        check("stuck2_cnt", A_FAIL_CNT, EXP_CNT);

        stuck_addr = AW'(0);
        run_march(EXP_S0, 0, 0, "stuck0");
        check("stuck0_fail", {A_FAIL, A_FAIL_ADDR, A_FAIL_ELEM}, {1'b1, 2'd0, 3'd1});
        check("stuck0_cnt", A_FAIL_CNT, EXP_CNT);

        stuck_en = 1'b0;
        run_march(41, 10, 0, "busy_start");
        check("busy_start_result", {A_FAIL, A_FAIL_CNT}, '0);

        run_march(0, 0, 15, "midrun");
        @(negedge A_CLK);
        A_RST_N = 1'b1;
        repeat (4) @(posedge A_CLK);
        #1 check("idle_after_midrun_reset", {A_BUSY, A_DONE, A_BIST_EN, A_BIST_MEN}, '0);

        run_march(41, 0, 0, "after_reset");
        check("after_reset_result", {A_FAIL, A_FAIL_CNT}, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
